// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the jump-label table loader
// Purpose: label index/address types, loader FSM states, table geometry.
// Ports: none (package).
package cpu_pkg;

  localparam int IDX_W      = 4;
  localparam int ADDR_W     = 16;
  localparam int NUM_LABELS = 16;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 16'd255;

  typedef logic [IDX_W-1:0]  label_idx_t;
  typedef logic [ADDR_W-1:0] jmp_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/jump_label_loader_if.sv
// rtl/jump_label_loader_if.sv - program-loader stream, status and lookup bundle
// Purpose: groups the label stream, load control/status and lookup port.
// Ports (signals): load_start, lbl_valid/lbl_ready/lbl_idx/lbl_addr/lbl_last,
//   busy, load_done, load_err, lookup_en/lookup_idx/lookup_addr/lookup_hit.
//   master = program loader / fetch side, slave = jump_label_loader.
interface jump_label_loader_if;
  import cpu_pkg::*;

  logic       load_start;
  logic       lbl_valid;
  logic       lbl_ready;
  label_idx_t lbl_idx;
  jmp_addr_t  lbl_addr;
  logic       lbl_last;
  logic       busy;
  logic       load_done;
  logic       load_err;
  logic       lookup_en;
  label_idx_t lookup_idx;
  jmp_addr_t  lookup_addr;
  logic       lookup_hit;

  modport master (
    output load_start, lbl_valid, lbl_idx, lbl_addr, lbl_last, lookup_en, lookup_idx,
    input  lbl_ready, busy, load_done, load_err, lookup_addr, lookup_hit
  );

  modport slave (
    input  load_start, lbl_valid, lbl_idx, lbl_addr, lbl_last, lookup_en, lookup_idx,
    output lbl_ready, busy, load_done, load_err, lookup_addr, lookup_hit
  );

endinterface

// File: rtl/label_table_ram.sv
// rtl/label_table_ram.sv - 16-entry jump-target storage with valid bits
// Purpose: single write port, combinational valid probe (duplicate check),
//   registered lookup port gated by rd_allow.
// Ports: clk, rst_n; we/wr_idx/wr_addr/wr_valid write port;
//   chk_idx -> chk_valid; rd_en/rd_idx/rd_allow -> rd_addr/rd_hit (1-cycle).
module label_table_ram
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  label_idx_t wr_idx,
  input  jmp_addr_t  wr_addr,
  input  logic       wr_valid,
  input  label_idx_t chk_idx,
  output logic       chk_valid,
  input  logic       rd_en,
  input  label_idx_t rd_idx,
  input  logic       rd_allow,
  output jmp_addr_t  rd_addr,
  output logic       rd_hit
);

  jmp_addr_t             mem [NUM_LABELS];
  logic [NUM_LABELS-1:0] valid;
  logic                  rd_hit_d;

  // Address storage carries no reset so it can map onto RAM; validity
  // lives in flops and is the only thing reset clears.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  valid <= '0;
    else if (we) valid[wr_idx] <= wr_valid;
  end

  assign chk_valid = valid[chk_idx];
  assign rd_hit_d  = valid[rd_idx] & rd_allow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_hit  <= 1'b0;
    end else if (rd_en) begin
      rd_hit  <= rd_hit_d;
      rd_addr <= rd_hit_d ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/jump_label_loader.sv
// rtl/jump_label_loader.sv - runtime loader for the CPU jump-label table
// Purpose: clears the table, accepts (index, address) pairs, tracks
//   duplicate/range errors per load, serves registered lookups when idle.
// Ports: clk, rst_n (async, active-low); bus (jump_label_loader_if.slave).
module jump_label_loader
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  jump_label_loader_if.slave    bus
);

  loader_state_e state;
  label_idx_t    clr_cnt;
  logic          lbl_ready_q;
  logic          busy_q;
  logic          load_done_q;
  logic          load_err_q;

  logic          xfer;
  logic          dup;
  logic          range_err;
  logic          we;
  label_idx_t    wr_idx;
  jmp_addr_t     wr_addr;
  logic          wr_valid;

  assign xfer      = (state == LOAD) & bus.lbl_valid & lbl_ready_q;
  assign range_err = bus.lbl_addr > MAX_ADDR;

  // CLEAR and LOAD share the single write port; they never overlap.
  always_comb begin
    we       = 1'b0;
    wr_idx   = bus.lbl_idx;
    wr_addr  = bus.lbl_addr;
    wr_valid = 1'b1;
    if (state == CLEAR) begin
      we       = 1'b1;
      wr_idx   = clr_cnt;
      wr_addr  = '0;
      wr_valid = 1'b0;
    end else if (xfer && !dup && !range_err) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      lbl_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            load_err_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == label_idx_t'(NUM_LABELS - 1)) begin
            state       <= LOAD;
            lbl_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (dup || range_err) load_err_q <= 1'b1;
            if (bus.lbl_last) begin
              state       <= DONE;
              lbl_ready_q <= 1'b0;
              busy_q      <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  label_table_ram u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wr_idx    (wr_idx),
    .wr_addr   (wr_addr),
    .wr_valid  (wr_valid),
    .chk_idx   (bus.lbl_idx),
    .chk_valid (dup),
    .rd_en     (bus.lookup_en),
    .rd_idx    (bus.lookup_idx),
    .rd_allow  (state == IDLE),
    .rd_addr   (bus.lookup_addr),
    .rd_hit    (bus.lookup_hit)
  );

  assign bus.lbl_ready = lbl_ready_q;
  assign bus.busy      = busy_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_jump_label_loader.sv
// tb/tb_jump_label_loader.sv - self-checking bench for jump_label_loader
module tb_jump_label_loader;
  import cpu_pkg::*;

  typedef struct { int idx; int addr; bit last; } pair_t;
  typedef struct { int idx; bit hit; int addr; } look_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jump_label_loader_if bus();

  jump_label_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: what the table should hold after each accepted pair.
  int m_addr  [NUM_LABELS];
  bit m_valid [NUM_LABELS];
  bit m_err;

  pair_t load1 [5];
  look_t look1 [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_LABELS; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic start_load();
    int n;
    int clr;
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    n = 0;
    clr = 0;
    while (!bus.lbl_ready && n < 64) begin
      if (bus.busy) clr++;
      n++;
      @(negedge clk);
    end
    check("clear_cycles", 32'(clr), 32'(NUM_LABELS));
    check("ready_in_load", 32'(bus.lbl_ready), 32'(1));
    check("busy_in_load", 32'(bus.busy), 32'(1));
    model_clear();
  endtask

  task automatic send_pair(input int idx, input int addr, input bit last);
    bus.lbl_valid = 1'b1;
    bus.lbl_idx   = label_idx_t'(idx);
    bus.lbl_addr  = jmp_addr_t'(addr);
    bus.lbl_last  = last;
    @(negedge clk);
    bus.lbl_valid = 1'b0;
    bus.lbl_last  = 1'b0;
    if (m_valid[idx] || addr > int'(MAX_ADDR)) m_err = 1'b1;
    else begin
      m_valid[idx] = 1'b1;
      m_addr[idx]  = addr;
    end
    if (last) begin
      check("load_done", 32'(bus.load_done), 32'(1));
      check("load_err", 32'(bus.load_err), 32'(m_err));
      check("ready_in_done", 32'(bus.lbl_ready), 32'(0));
      @(negedge clk);
      check("done_width", 32'(bus.load_done), 32'(0));
    end
  endtask

  task automatic lookup(input int idx, input bit idle, input string name);
    bit h;
    bus.lookup_en  = 1'b1;
    bus.lookup_idx = label_idx_t'(idx);
    @(negedge clk);
    bus.lookup_en = 1'b0;
    h = idle && m_valid[idx];
    check({name, "_hit"}, 32'(bus.lookup_hit), 32'(h));
    check({name, "_addr"}, 32'(bus.lookup_addr), h ? 32'(m_addr[idx]) : 32'(0));
  endtask

  initial begin
    int cnt;
    int np;

    load1[0] = '{0, 10, 1'b0};
    load1[1] = '{1, 22, 1'b0};
    load1[2] = '{6, 8, 1'b0};
    load1[3] = '{7, 39, 1'b0};
    load1[4] = '{11, 60, 1'b1};
    look1[0] = '{7, 1'b1, 39};
    look1[1] = '{3, 1'b0, 0};
    look1[2] = '{0, 1'b1, 10};
    look1[3] = '{11, 1'b1, 60};

    bus.load_start = 1'b0;
    bus.lbl_valid  = 1'b0;
    bus.lbl_idx    = '0;
    bus.lbl_addr   = '0;
    bus.lbl_last   = 1'b0;
    bus.lookup_en  = 1'b0;
    bus.lookup_idx = '0;
    model_clear();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.lbl_ready), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.load_done), 32'(0));
    check("rst_err", 32'(bus.load_err), 32'(0));
    check("rst_laddr", 32'(bus.lookup_addr), 32'(0));
    check("rst_lhit", 32'(bus.lookup_hit), 32'(0));
    rst_n = 1'b1;

    // Basic load from the vector table, constant expectations for lookups
    start_load();
    for (int i = 0; i < 5; i++) send_pair(load1[i].idx, load1[i].addr, load1[i].last);
    for (int i = 0; i < 4; i++) begin
      bus.lookup_en  = 1'b1;
      bus.lookup_idx = label_idx_t'(look1[i].idx);
      @(negedge clk);
      bus.lookup_en = 1'b0;
      check($sformatf("tbl_hit%0d", i), 32'(bus.lookup_hit), 32'(look1[i].hit));
      check($sformatf("tbl_addr%0d", i), 32'(bus.lookup_addr), 32'(look1[i].addr));
    end
    // Outputs hold while lookup_en is low
    lookup(7, 1'b1, "lk7");
    bus.lookup_idx = label_idx_t'(3);
    repeat (3) @(negedge clk);
    check("hold_addr", 32'(bus.lookup_addr), 32'(39));
    check("hold_hit", 32'(bus.lookup_hit), 32'(1));

    // Duplicate index: first definition wins
    start_load();
    send_pair(8, 18, 1'b0);
    send_pair(8, 46, 1'b1);
    check("dup_err", 32'(bus.load_err), 32'(1));
    lookup(8, 1'b1, "dup8");
    check("dup8_const", 32'(bus.lookup_addr), 32'(18));

    // Address above MAX_ADDR rejected
    start_load();
    send_pair(9, 300, 1'b1);
    lookup(9, 1'b1, "range9");
    check("range9_const", 32'(bus.lookup_hit), 32'(0));

    // Lookups during LOAD miss; pair + lookup same cycle; new value after done
    start_load();
    send_pair(6, 8, 1'b1);
    start_load();
    lookup(6, 1'b0, "inload6");
    bus.lookup_en  = 1'b1;
    bus.lookup_idx = label_idx_t'(6);
    send_pair(5, 5, 1'b0);
    bus.lookup_en = 1'b0;
    check("simul_hit", 32'(bus.lookup_hit), 32'(0));
    check("simul_addr", 32'(bus.lookup_addr), 32'(0));
    send_pair(6, 77, 1'b1);
    lookup(6, 1'b1, "after6");
    check("after6_const", 32'(bus.lookup_addr), 32'(77));
    lookup(5, 1'b1, "after5");

    // Reset mid-LOAD after three pairs
    start_load();
    send_pair(1, 11, 1'b0);
    send_pair(2, 12, 1'b0);
    send_pair(3, 13, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'(0));
    check("mid_rst_ready", 32'(bus.lbl_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.load_done) cnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", 32'(cnt), 32'(0));
    for (int i = 0; i < NUM_LABELS; i++) lookup(i, 1'b1, $sformatf("rst_miss%0d", i));
    start_load();
    send_pair(4, 44, 1'b1);
    lookup(4, 1'b1, "post_rst4");

    // Long idle in LOAD, ignored load_start, then a single last pair
    start_load();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.load_start = (i == 5);
      if (!bus.lbl_ready || !bus.busy) cnt++;
      @(negedge clk);
    end
    bus.load_start = 1'b0;
    check("idle_ready_held", 32'(cnt), 32'(0));
    check("idle_ready_end", 32'(bus.lbl_ready), 32'(1));
    send_pair(2, 99, 1'b1);
    lookup(2, 1'b1, "idle2");

    // Randomized loads against the model
    for (int r = 0; r < 6; r++) begin
      start_load();
      np = int'($urandom_range(1, 10));
      for (int k = 0; k < np; k++) begin
        if ($urandom_range(0, 2) == 0) lookup(int'($urandom_range(0, 15)), 1'b0, "rnd_inload");
        else if ($urandom_range(0, 1) == 0) @(negedge clk);
        send_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 320)), k == np - 1);
      end
      for (int i = 0; i < NUM_LABELS; i++) lookup(i, 1'b1, $sformatf("rnd%0d_%0d", r, i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jump_label_loader.md
Name: jump_label_loader

Overview:
- Writer side of the CPU's jump-label table. It accepts (label index, target address) pairs from the program loader over a valid/ready stream and stores them in a 16-entry table.
- The fetch-path next-PC mux reads the table through a registered lookup port.
- Replaces the hard-coded label initialisation with a runtime-loaded table: clear, load, and validity/error tracking per program load.

Parameters:
- NUM_LABELS, 16, table entries; must equal 2**IDX_W
- IDX_W, 4, label index width
- ADDR_W, 16, jump target address width
- MAX_ADDR, 16'd255, highest legal target address (instruction memory top)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  single-cycle pulse; begins a new program load
- lbl_valid  in  1  label pair valid
- lbl_ready  out  1  block accepts pair this cycle
- lbl_idx  in  IDX_W  label index
- lbl_addr  in  ADDR_W  label target address
- lbl_last  in  1  marks final pair of the load
- busy  out  1  high in CLEAR or LOAD
- load_done  out  1  single-cycle pulse when load completes
- load_err  out  1  sticky error for the current load; cleared by next load_start
- lookup_en  in  1  lookup request
- lookup_idx  in  IDX_W  index to read
- lookup_addr  out  ADDR_W  registered target address
- lookup_hit  out  1  registered; entry valid and table ready

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - Outputs: lbl_ready=0, busy=0, load_done=0, load_err=0, lookup_addr=0, lookup_hit=0.
  - State: all valid bits=0, FSM=IDLE.
- Storage: table entries are addr[NUM_LABELS] x ADDR_W plus valid[NUM_LABELS]. Entries are not reset by rst_n (RAM-friendly); the valid bits are.
- FSM states: IDLE, CLEAR, LOAD, DONE.
- IDLE:
  - lbl_ready=0.
  - load_start -> CLEAR; the clear counter is set to 0 and load_err is cleared.
- CLEAR:
  - One entry per cycle: addr[cnt]=0, valid[cnt]=0; takes exactly NUM_LABELS cycles.
  - After the entry with cnt=NUM_LABELS-1 -> LOAD.
- LOAD:
  - lbl_ready=1. A transfer occurs on lbl_valid & lbl_ready.
  - Accept rules:
    - Duplicate (valid[lbl_idx]=1): no write; load_err set. The first definition wins.
    - lbl_addr > MAX_ADDR: no write; load_err set.
    - Otherwise: write addr[lbl_idx]=lbl_addr and set valid[lbl_idx]=1.
  - Transfer with lbl_last=1 -> DONE, after applying that pair's write and error rules.
  - lbl_valid=0 simply waits; there is no timeout.
- DONE: load_done=1 for exactly one cycle, lbl_ready=0, then -> IDLE.
- load_start outside IDLE is ignored.
- Lookup (1-cycle latency):
  - When lookup_en is sampled at edge N, lookup_addr and lookup_hit update at edge N+1.
  - lookup_hit = valid[lookup_idx] & state==IDLE.
  - lookup_addr = addr[lookup_idx] if hit, else 0.
  - When lookup_en=0, both outputs hold their previous values.
  - Lookups during CLEAR/LOAD/DONE return hit=0, addr=0. The table is only trustworthy after load_done.
- Simultaneous events:
  - A pair and a lookup in the same LOAD cycle: the lookup returns a miss; the write proceeds.
  - A duplicate index within the same load with different addresses: the first address is retained.
- Reset mid-operation (any state): asserting rst_n low returns the FSM to IDLE and clears all valid bits and outputs immediately. A partial load is discarded; no load_done pulse.
- Width rules: lbl_addr is compared unsigned against MAX_ADDR at full ADDR_W. No truncation.

Decomposition:
- Package cpu_pkg holds:
  - the typedef label_idx_t (IDX_W bits) and the typedef jmp_addr_t (ADDR_W bits);
  - the enum loader_state_e {IDLE, CLEAR, LOAD, DONE};
  - the constants NUM_LABELS and MAX_ADDR.
- One natural sub-module: label_table_ram, the 16x16 storage with a single write port, registered read port and separate valid-bit register. The FSM and error logic stay in the top level.

Test Plan:
- Reset, then load_start; send (0,10) (1,22) (6,8) (7,39) (11,60 last). Required:
  - exactly 16 CLEAR cycles with busy=1;
  - one load_done pulse, load_err=0;
  - lookup 7 -> addr=39, hit=1 one cycle later;
  - lookup 3 -> addr=0, hit=0.
- Load (8,18) then (8,46 last) -> load_err=1; lookup 8 -> 18.
- Load (9,300 last) with MAX_ADDR=255 -> load_err=1; lookup 9 -> hit=0, addr=0.
- Issue lookup_en with idx 6 while in LOAD after a prior load that defined 6 -> hit=0, addr=0. After load_done, the same lookup returns the newly loaded value.
- Drop rst_n for 1 cycle mid-LOAD after 3 pairs. Required:
  - busy=0 and lbl_ready=0 immediately; no load_done;
  - all lookups miss;
  - a subsequent load works normally.
- Hold lbl_valid=0 for 20 cycles in LOAD, then send one pair with lbl_last=1 -> lbl_ready stays 1 throughout; load_done follows the transfer by 1 cycle. A load_start during LOAD is ignored.
